tff_mod_counter: RTL and testbench

TFF_MOD_COUNTER -- requirements
Module: tff_mod_counter

---
 rtl/tff_cnt_pkg.sv | 25 ++
 rtl/tff_mod_counter_t_cell.sv | 45 ++++
 rtl/tff_mod_counter.sv | 166 ++++++++++++++++
 tb/tb_tff_mod_counter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/tff_cnt_pkg.sv
// ---------------------------------------------------------------------------
// tff_cnt_pkg
// Shared constants and types for the T-flip-flop modulo counter.
//   WIDTH_DEFAULT : default counter width in bits
//   DIR_UP        : value of 'up' that selects counting up
//   DIR_DOWN      : value of 'up' that selects counting down
//   cnt_act_e     : per-cycle action chosen by the counter control logic
// ---------------------------------------------------------------------------
package tff_cnt_pkg;

  localparam int   WIDTH_DEFAULT = 4;
  localparam logic DIR_UP        = 1'b1;
  localparam logic DIR_DOWN      = 1'b0;

  // One action per cycle; the wrap actions are the only ones that raise tc/ovf.
  typedef enum logic [2:0] {
    ACT_HOLD    = 3'd0,
    ACT_LOAD    = 3'd1,
    ACT_INC     = 3'd2,
    ACT_DEC     = 3'd3,
    ACT_WRAP_LO = 3'd4,  // counting up past mod_max, land on 0
    ACT_WRAP_HI = 3'd5   // counting down past 0 (or from above mod_max), land on mod_max
  } cnt_act_e;

endpackage : tff_cnt_pkg

// File: rtl/tff_mod_counter_t_cell.sv
// ---------------------------------------------------------------------------
// t_cell
// One-bit T flip-flop with synchronous active-high reset.
//   clk : clock, state changes on rising edge
//   rst : synchronous reset, forces q to 0 (overrides t)
//   t   : toggle request, q inverts at the edge when t=1
//   q   : stored bit
//   qb  : complement of q
// ---------------------------------------------------------------------------
module t_cell
  import tff_cnt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qb
);

  logic q_q;
  logic q_d;

  // Next bit value: invert on toggle, otherwise keep.
  always_comb begin
    q_d = q_q;
    if (t) begin
      q_d = ~q_q;
    end else begin
      q_d = q_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule : t_cell

// File: rtl/tff_mod_counter.sv
// ---------------------------------------------------------------------------
// tff_mod_counter
// Up/down modulo counter built from WIDTH T flip-flops. The control logic
// works out the desired next count and feeds each cell the toggle vector
// T = q ^ next_q, so the cells only ever toggle.
//   clk      : clock
//   rst      : synchronous active-high reset (q=0, tc=0, ovf=0)
//   en       : count enable
//   up       : direction, DIR_UP counts up, DIR_DOWN counts down
//   load     : parallel load of min(load_val, mod_max), beats en
//   load_val : load value
//   mod_max  : terminal value, count range 0..mod_max
//   q        : current count
//   qb       : bitwise complement of q
//   tc       : registered one-cycle pulse after each wrap
//   ovf      : sticky wrap flag, cleared by rst or load
// ---------------------------------------------------------------------------
module tff_mod_counter
  import tff_cnt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_max,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_s;
  logic [WIDTH-1:0] cnt_b_s;
  logic [WIDTH-1:0] next_cnt_s;
  logic [WIDTH-1:0] t_vec_s;
  logic [WIDTH-1:0] load_clip_s;
  cnt_act_e         act_s;

  logic tc_q;
  logic tc_d;
  logic ovf_q;
  logic ovf_d;

  // Clamp the load value into the legal range.
  always_comb begin
    load_clip_s = load_val;
    if (load_val > mod_max) begin
      load_clip_s = mod_max;
    end else begin
      load_clip_s = load_val;
    end
  end

  // Pick this cycle's action: load beats en, en beats hold. A count that is
  // above mod_max (mod_max lowered on the fly) wraps in either direction.
  always_comb begin
    act_s = ACT_HOLD;
    if (load) begin
      act_s = ACT_LOAD;
    end else if (en) begin
      if (up == DIR_UP) begin
        if (cnt_s < mod_max) begin
          act_s = ACT_INC;
        end else begin
          act_s = ACT_WRAP_LO;
        end
      end else begin
        if ((cnt_s == ZERO_W) || (cnt_s > mod_max)) begin
          act_s = ACT_WRAP_HI;
        end else begin
          act_s = ACT_DEC;
        end
      end
    end else begin
      act_s = ACT_HOLD;
    end
  end

  // Next count and flag values for the chosen action. The increment only
  // happens when cnt_s < mod_max and the decrement only when cnt_s > 0, so
  // WIDTH-bit arithmetic never wraps.
  always_comb begin
    next_cnt_s = cnt_s;
    tc_d       = 1'b0;
    ovf_d      = ovf_q;
    case (act_s)
      ACT_HOLD: begin
        next_cnt_s = cnt_s;
        tc_d       = 1'b0;
        ovf_d      = ovf_q;
      end
      ACT_LOAD: begin
        next_cnt_s = load_clip_s;
        tc_d       = 1'b0;
        ovf_d      = 1'b0;
      end
      ACT_INC: begin
        next_cnt_s = cnt_s + ONE_W;
        tc_d       = 1'b0;
        ovf_d      = ovf_q;
      end
      ACT_DEC: begin
        next_cnt_s = cnt_s - ONE_W;
        tc_d       = 1'b0;
        ovf_d      = ovf_q;
      end
      ACT_WRAP_LO: begin
        next_cnt_s = ZERO_W;
        tc_d       = 1'b1;
        ovf_d      = 1'b1;
      end
      ACT_WRAP_HI: begin
        next_cnt_s = mod_max;
        tc_d       = 1'b1;
        ovf_d      = 1'b1;
      end
      default: begin
        next_cnt_s = cnt_s;
        tc_d       = 1'b0;
        ovf_d      = ovf_q;
      end
    endcase
  end

  // Cells only see toggles; a bit flips exactly where current and next differ.
  always_comb begin
    t_vec_s = cnt_s ^ next_cnt_s;
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      t_cell u_cell (
        .clk (clk),
        .rst (rst),
        .t   (t_vec_s[gi]),
        .q   (cnt_s[gi]),
        .qb  (cnt_b_s[gi])
      );
    end
  endgenerate

  // Terminal-count pulse and sticky wrap flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = cnt_s;
  assign qb  = cnt_b_s;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule : tff_mod_counter

// File: tb/tb_tff_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_tff_mod_counter
// Directed scenarios followed by randomized cycles, each checked against a
// behavioural model of the modulo counter written with integer arithmetic.
// ---------------------------------------------------------------------------
module tb_tff_mod_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] mod_max;
  logic [W-1:0] q;
  logic [W-1:0] qb;
  logic         tc;
  logic         ovf;

  int n_cmp;
  int n_mis;

  // Reference state
  int m_q;
  int m_tc;
  int m_ovf;

  tff_mod_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .mod_max  (mod_max),
    .q        (q),
    .qb       (qb),
    .tc       (tc),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour: count modulo mod_max+1, wrap raises tc/ovf.
  task automatic model_edge(input logic r, input logic ld, input logic e,
                            input logic u, input int lv, input int mm);
    int nxt;
    if (r) begin
      m_q = 0; m_tc = 0; m_ovf = 0;
    end else if (ld) begin
      m_q = (lv < mm) ? lv : mm;
      m_tc = 0; m_ovf = 0;
    end else if (e) begin
      if (u) begin
        nxt = m_q + 1;
        if (nxt > mm) begin m_q = 0; m_tc = 1; m_ovf = 1; end
        else begin m_q = nxt; m_tc = 0; end
      end else begin
        nxt = m_q - 1;
        if (nxt < 0 || m_q > mm) begin m_q = mm; m_tc = 1; m_ovf = 1; end
        else begin m_q = nxt; m_tc = 0; end
      end
    end else begin
      m_tc = 0;
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, compare outputs.
  task automatic step(input string tag, input logic r, input logic ld,
                      input logic e, input logic u, input int lv, input int mm);
    @(negedge clk);
    rst = r; load = ld; en = e; up = u;
    load_val = lv[W-1:0]; mod_max = mm[W-1:0];
    @(posedge clk);
    model_edge(r, ld, e, u, lv, mm);
    #1;
    chk({tag, ".q"},   int'(q),   m_q);
    chk({tag, ".qb"},  int'(qb),  (~m_q) & 15);
    chk({tag, ".tc"},  int'(tc),  m_tc);
    chk({tag, ".ovf"}, int'(ovf), m_ovf);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    m_q = 0; m_tc = 0; m_ovf = 0;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
    load_val = 4'h0; mod_max = 4'h9;

    // Reset two cycles, then release with en=0
    step("rst0", 1'b1, 1'b0, 1'b0, 1'b1, 0, 9);
    step("rst1", 1'b1, 1'b1, 1'b1, 1'b1, 5, 9);
    chk("rst.qb_all_ones", int'(qb), 15);
    step("idle0", 1'b0, 1'b0, 1'b0, 1'b1, 0, 9);
    step("idle1", 1'b0, 1'b0, 1'b0, 1'b1, 0, 9);

    // Count up mod 10 for 12 cycles: 1..9,0,1,2
    for (int i = 0; i < 12; i++) begin
      step("up9", 1'b0, 1'b0, 1'b1, 1'b1, 0, 9);
      if (i == 9) chk("up9.wrap_tc", int'(tc), 1);
    end
    chk("up9.end_q", int'(q), 2);
    chk("up9.ovf_sticky", int'(ovf), 1);

    // Load above mod_max clips to 9, then count down 8,7,6
    step("ldC", 1'b0, 1'b1, 1'b1, 1'b1, 12, 9);
    chk("ldC.clip", int'(q), 9);
    for (int i = 0; i < 3; i++) step("dn", 1'b0, 1'b0, 1'b1, 1'b0, 0, 9);
    chk("dn.end_q", int'(q), 6);

    // Down-wrap from 0 with mod_max=5, then load clears ovf
    step("ld0", 1'b0, 1'b1, 1'b0, 1'b0, 0, 5);
    step("dnwrap", 1'b0, 1'b0, 1'b1, 1'b0, 0, 5);
    chk("dnwrap.q", int'(q), 5);
    step("dnwrap_hold", 1'b0, 1'b0, 1'b0, 1'b0, 0, 5);
    step("ld_clr", 1'b0, 1'b1, 1'b0, 1'b0, 2, 5);
    chk("ld_clr.ovf", int'(ovf), 0);

    // mod_max lowered below q while counting up, then rst beats load
    step("ld7", 1'b0, 1'b1, 1'b0, 1'b1, 7, 9);
    step("mm3", 1'b0, 1'b0, 1'b1, 1'b1, 0, 3);
    chk("mm3.q", int'(q), 0);
    step("rst_ld", 1'b1, 1'b1, 1'b1, 1'b1, 6, 9);
    step("ld7b", 1'b0, 1'b1, 1'b0, 1'b1, 7, 9);
    step("dn_above", 1'b0, 1'b0, 1'b1, 1'b0, 0, 3);

    // mod_max=0: q stuck at 0, tc every enabled cycle
    for (int i = 0; i < 4; i++) step("mm0", 1'b0, 1'b0, 1'b1, i[0], 0, 0);
    step("mm0_off", 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);

    // Randomized cycles
    begin
      int mm_r;
      mm_r = 9;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(15) == 0) mm_r = $urandom_range(15);
        step("rand",
             ($urandom_range(39) == 0),
             ($urandom_range(9) == 0),
             ($urandom_range(3) != 0),
             $urandom_range(1) == 1,
             $urandom_range(15),
             mm_r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_tff_mod_counter
